// File: rtl/weight_stream_pkg.sv
// Shared types and default sizing for the weight stream controller.
package weight_stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  localparam int DEF_ROM_LATENCY = 2;
  localparam int DEF_FIFO_DEPTH  = 4;

endpackage

// File: rtl/weight_stream_if.sv
// Control, ROM read port and output stream of the weight stream controller.
// Stream handshake: a word moves on every rising edge where data_out_valid && data_out_ready;
// data_out_valid never depends on data_out_ready, and data_out holds while valid && !ready.
interface weight_stream_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 6,
  parameter int PASS_WIDTH = 16
);
  logic                  start;
  logic [PASS_WIDTH-1:0] pass_count;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic                  rom_ce;
  logic [DATA_WIDTH-1:0] rom_q;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_out_valid;
  logic                  data_out_ready;

  modport master (
    input  start, pass_count, rom_q, data_out_ready,
    output busy, done, rom_addr, rom_ce, data_out, data_out_valid
  );

  modport slave (
    output start, pass_count, rom_q, data_out_ready,
    input  busy, done, rom_addr, rom_ce, data_out, data_out_valid
  );
endinterface

// File: rtl/weight_stream_fifo.sv
// Show-ahead output FIFO: rdata is the head entry whenever empty is low.
module weight_stream_fifo
  import weight_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [CW-1:0]         count,
  output logic                  empty,
  output logic                  full
);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(FIFO_DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage is cleared on reset so data_out reads zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/weight_stream_ctrl.sv
// Turns a fixed-latency parameter ROM into a credit-limited valid/ready stream,
// replaying the DEPTH-word tensor pass_count times.
module weight_stream_ctrl
  import weight_stream_pkg::*;
#(
  parameter int DATA_WIDTH  = 128,
  parameter int DEPTH       = 32,
  parameter int ADDR_WIDTH  = $clog2(DEPTH) + 1,
  parameter int ROM_LATENCY = DEF_ROM_LATENCY,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int PASS_WIDTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  weight_stream_if.master   bus,
  output state_t            fsm_state
);

  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int ICW = $clog2(ROM_LATENCY + 1);
  localparam int CW  = $clog2(FIFO_DEPTH + ROM_LATENCY + 1);

  state_t                  state;
  state_t                  state_nxt;
  logic                    done_q;
  logic                    done_nxt;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [PASS_WIDTH-1:0]   pass;
  logic [PASS_WIDTH-1:0]   pass_total;
  logic [ROM_LATENCY-1:0]  inflight_sr;
  logic [ICW-1:0]          inflight_cnt;
  logic [CW-1:0]           credit_used;
  logic                    issue;
  logic                    last_word;
  logic                    launch;
  logic                    capture;
  logic                    pop;
  logic [FCW-1:0]          fifo_count;
  logic                    fifo_empty;
  logic                    fifo_full;

  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < ROM_LATENCY; i++) inflight_cnt = inflight_cnt + ICW'(inflight_sr[i]);
  end

  // Every word either sits in the FIFO or is still in the ROM pipeline, so
  // bounding their sum by FIFO_DEPTH guarantees a free slot at capture time.
  assign credit_used = CW'(fifo_count) + CW'(inflight_cnt);
  assign issue       = (state == STREAM) && (credit_used < CW'(FIFO_DEPTH));
  assign last_word   = (addr == ADDR_WIDTH'(DEPTH - 1)) && (pass == pass_total - 1'b1);
  assign launch      = (state == IDLE) && bus.start && (bus.pass_count != '0);
  assign capture     = inflight_sr[ROM_LATENCY-1] && !fifo_full;
  assign pop         = bus.data_out_ready && !fifo_empty;

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.pass_count != '0) state_nxt = STREAM;
          else                      done_nxt  = 1'b1;
        end
      end
      STREAM: begin
        if (issue && last_word) state_nxt = DRAIN;
      end
      DRAIN: begin
        if ((inflight_cnt == '0) && fifo_empty) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= done_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr        <= '0;
      pass        <= '0;
      pass_total  <= '0;
      inflight_sr <= '0;
    end else begin
      inflight_sr <= (inflight_sr << 1) | ROM_LATENCY'(issue);
      if (launch) begin
        pass_total <= bus.pass_count;
        addr       <= '0;
        pass       <= '0;
      end else if (issue) begin
        if (addr == ADDR_WIDTH'(DEPTH - 1)) begin
          addr <= '0;
          pass <= pass + 1'b1;
        end else begin
          addr <= addr + 1'b1;
        end
      end
    end
  end

  weight_stream_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (capture),
    .wdata (bus.rom_q),
    .pop   (pop),
    .rdata (bus.data_out),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign bus.busy           = (state != IDLE);
  assign bus.done           = done_q;
  assign bus.rom_addr       = addr;
  assign bus.rom_ce         = 1'b1;
  assign bus.data_out_valid = !fifo_empty;
  assign fsm_state          = state;

endmodule

// File: tb/tb_weight_stream_ctrl.sv
// Directed bench for weight_stream_ctrl against a 2-cycle ROM model.
module tb_weight_stream_ctrl;
  import weight_stream_pkg::*;

  localparam int DW    = 128;
  localparam int DEPTH = 32;
  localparam int AW    = 6;
  localparam int PW    = 16;

  logic   clk = 1'b0;
  logic   rst;
  state_t fsm_state;

  always #5 clk = ~clk;

  weight_stream_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PASS_WIDTH(PW)) bus ();

  weight_stream_ctrl #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW),
    .ROM_LATENCY(2),
    .FIFO_DEPTH (4),
    .PASS_WIDTH (PW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.master),
    .fsm_state (fsm_state)
  );

  function automatic logic [DW-1:0] rom_word(input logic [5:0] a);
    return {26'h2A5A5A5, a, 32'hDEAD_0000 + {26'd0, a}, {a, 26'h1555555}, {16{~a[1:0]}}};
  endfunction

  // ROM model: address sampled on an enabled edge, data two edges later.
  logic [DW-1:0] rom_p1, rom_p2;
  always @(posedge clk) begin
    if (bus.rom_ce) begin
      rom_p1 <= rom_word(bus.rom_addr);
      rom_p2 <= rom_p1;
    end
  end
  assign bus.rom_q = rom_p2;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q[$];

  int edge_cnt, start_edge, words, done_cnt, done_edge, last_acc_edge, first_valid_edge, max_fifo;
  bit busy_seen;

  typedef struct {
    int passes;
    int pct;
    int exp_words;
    int exp_lat;
    int exp_done_gap;
    int exp_span;
    int exp_busy;
  } vec_t;
  vec_t vecs[5];

  task automatic check_int(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic check_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic clear_stats();
    words = 0; done_cnt = 0; done_edge = -1; last_acc_edge = -1;
    first_valid_edge = -1; max_fifo = 0; busy_seen = 1'b0;
  endtask

  // Observe one cycle with the given ready, scoreboard any transfer, then cross the edge.
  task automatic cycle(input bit rdy);
    bus.data_out_ready = rdy;
    if (bus.data_out_valid && first_valid_edge < 0) first_valid_edge = edge_cnt;
    if (bus.data_out_valid && rdy) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL extra_word: got %h expected no word", bus.data_out);
      end else begin
        check_data("word", bus.data_out, exp_q.pop_front());
      end
      words++;
      last_acc_edge = edge_cnt + 1;
    end
    if (bus.done) begin
      done_cnt++;
      done_edge = edge_cnt;
    end
    if (bus.busy) busy_seen = 1'b1;
    if (int'(dut.fifo_count) > max_fifo) max_fifo = int'(dut.fifo_count);
    @(posedge clk);
    #1;
    edge_cnt++;
  endtask

  task automatic launch(input int n);
    for (int p = 0; p < n; p++)
      for (int a = 0; a < DEPTH; a++) exp_q.push_back(rom_word(6'(a)));
    bus.start      = 1'b1;
    bus.pass_count = PW'(n);
    cycle(1'b1);
    start_edge     = edge_cnt;
    bus.start      = 1'b0;
  endtask

  task automatic run_until_done(input int pct, input int limit);
    int k = 0;
    while (done_cnt == 0 && k < limit) begin
      cycle($urandom_range(0, 99) < pct);
      k++;
    end
    if (done_cnt == 0) begin
      total++; bad++;
      $display("FAIL done_timeout: got no done expected done within %0d cycles", limit);
    end
    for (int i = 0; i < 4; i++) cycle(1'b1);
  endtask

  initial begin
    int lat, gap, span, addr_before, k, changes;
    logic [DW-1:0] held;

    vecs[0] = '{passes: 1, pct: 100, exp_words: 32, exp_lat: 3,  exp_done_gap: 1, exp_span: 32, exp_busy: 1};
    vecs[1] = '{passes: 3, pct: 50,  exp_words: 96, exp_lat: 3,  exp_done_gap: 1, exp_span: -1, exp_busy: 1};
    vecs[2] = '{passes: 0, pct: 100, exp_words: 0,  exp_lat: -1, exp_done_gap: 0, exp_span: -1, exp_busy: 0};
    vecs[3] = '{passes: 2, pct: 100, exp_words: 64, exp_lat: 3,  exp_done_gap: 1, exp_span: 64, exp_busy: 1};
    vecs[4] = '{passes: 1, pct: 25,  exp_words: 32, exp_lat: 3,  exp_done_gap: 1, exp_span: -1, exp_busy: 1};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.pass_count = '0;
    bus.data_out_ready = 1'b0;
    edge_cnt = 0;
    #2;
    check_int("reset_busy", int'(bus.busy), 0);
    check_int("reset_done", int'(bus.done), 0);
    check_int("reset_valid", int'(bus.data_out_valid), 0);
    check_data("reset_data", bus.data_out, '0);
    check_int("reset_addr", int'(bus.rom_addr), 0);
    check_int("reset_state", int'(fsm_state), int'(IDLE));
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle(1'b0);

    for (int v = 0; v < 5; v++) begin
      clear_stats();
      addr_before = int'(bus.rom_addr);
      launch(vecs[v].passes);
      run_until_done(vecs[v].pct, 3000);
      lat  = (first_valid_edge < 0) ? -1 : first_valid_edge - start_edge;
      gap  = (words == 0) ? done_edge - start_edge : done_edge - last_acc_edge;
      span = last_acc_edge - first_valid_edge;
      check_int($sformatf("v%0d_words", v), words, vecs[v].exp_words);
      check_int($sformatf("v%0d_first_valid", v), lat, vecs[v].exp_lat);
      check_int($sformatf("v%0d_done_count", v), done_cnt, 1);
      check_int($sformatf("v%0d_done_gap", v), gap, vecs[v].exp_done_gap);
      check_int($sformatf("v%0d_busy_seen", v), int'(busy_seen), vecs[v].exp_busy);
      check_int($sformatf("v%0d_fifo_bound", v), int'(max_fifo <= 4), 1);
      check_int($sformatf("v%0d_leftover", v), exp_q.size(), 0);
      if (vecs[v].exp_span >= 0) check_int($sformatf("v%0d_span", v), span, vecs[v].exp_span);
      if (vecs[v].passes == 0) check_int($sformatf("v%0d_addr_kept", v), int'(bus.rom_addr), addr_before);
    end

    // Stall: once ready drops, exactly four words are outstanding beyond those accepted.
    clear_stats();
    launch(1);
    for (int i = 0; i < 10; i++) cycle(1'b1);
    k = words;
    for (int i = 0; i < 3; i++) cycle(1'b0);
    held = bus.data_out;
    check_data("stall_head", held, rom_word(6'(k)));
    changes = 0;
    for (int i = 0; i < 17; i++) begin
      if (bus.data_out !== held || !bus.data_out_valid) changes++;
      cycle(1'b0);
    end
    check_int("stall_stable", changes, 0);
    check_int("stall_addr", int'(bus.rom_addr), k + 4);
    check_int("stall_fifo_bound", int'(max_fifo <= 4), 1);
    run_until_done(100, 3000);
    check_int("stall_words", words, 32);
    check_int("stall_done_count", done_cnt, 1);
    check_int("stall_leftover", exp_q.size(), 0);

    // A second start while busy must not change the job.
    clear_stats();
    launch(2);
    for (int i = 0; i < 20; i++) cycle(1'b1);
    bus.start = 1'b1;
    bus.pass_count = PW'(5);
    cycle(1'b1);
    bus.start = 1'b0;
    run_until_done(100, 3000);
    check_int("restart_words", words, 64);
    check_int("restart_done_count", done_cnt, 1);
    check_int("restart_leftover", exp_q.size(), 0);

    // Asynchronous reset mid-stream, then a clean single pass.
    clear_stats();
    launch(2);
    for (int i = 0; i < 40; i++) cycle(1'b1);
    #3;
    rst = 1'b1;
    #1;
    check_int("arst_busy", int'(bus.busy), 0);
    check_int("arst_done", int'(bus.done), 0);
    check_int("arst_valid", int'(bus.data_out_valid), 0);
    check_data("arst_data", bus.data_out, '0);
    check_int("arst_addr", int'(bus.rom_addr), 0);
    check_int("arst_state", int'(fsm_state), int'(IDLE));
    exp_q.delete();
    @(posedge clk);
    #1;
    edge_cnt++;
    rst = 1'b0;
    cycle(1'b0);
    clear_stats();
    launch(1);
    run_until_done(100, 3000);
    lat = (first_valid_edge < 0) ? -1 : first_valid_edge - start_edge;
    check_int("post_rst_words", words, 32);
    check_int("post_rst_first_valid", lat, 3);
    check_int("post_rst_done_count", done_cnt, 1);
    check_int("post_rst_leftover", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
